score_keeper: RTL and testbench

//  Goal detector and score counter; the producer of the player score buses consumed by the scoreboard draw stage.

---
 rtl/score_keeper.sv | 153 +++++++++++++++
 tb/tb_score_keeper.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: goal detector and score counter feeding the scoreboard draw stage.
// Samples the puck once per frame, awards points, and sequences the serve pause and end-of-game hold.
// Optional feature: define SCORE_AUTO_RESTART_EN to restart automatically after RESTART_FRAMES
// frame ticks in the game-over hold; otherwise game over is held until new_game or reset.
module score_keeper #(
  parameter int unsigned GOAL_L_X       = 20,
  parameter int unsigned GOAL_R_X       = 1003,
  parameter int unsigned GOAL_Y_MIN     = 284,
  parameter int unsigned GOAL_Y_MAX     = 483,
  parameter int unsigned WIN_SCORE      = 3,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned RESTART_FRAMES = 180
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_tick_i,
  input  logic [11:0] puck_x_i,
  input  logic [11:0] puck_y_i,
  input  logic        new_game_i,
  output logic [1:0]  player_1_point_o,
  output logic [1:0]  player_2_point_o,
  output logic        goal_pulse_o,
  output logic        serve_o,
  output logic        game_over_o,
  output logic [1:0]  winner_o
);

  localparam logic [1:0] StServe = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StGoal  = 2'd2;
  localparam logic [1:0] StOver  = 2'd3;

  // One counter serves both the serve pause and the restart hold.
  localparam int unsigned CntMax = (SERVE_FRAMES > RESTART_FRAMES) ? SERVE_FRAMES : RESTART_FRAMES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [1:0]      WinPts    = 2'(WIN_SCORE);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      p1_q, p1_d;
  logic [1:0]      p2_q, p2_d;
  logic            pulse_q, serve_q, over_q;
  logic [1:0]      winner_q, winner_d;
  logic            in_l, in_r, in_y;

  // Goal-mouth detection; only meaningful when frame_tick_i is high.
  always_comb begin
    in_y = (puck_y_i >= 12'(GOAL_Y_MIN)) && (puck_y_i <= 12'(GOAL_Y_MAX));
    in_r = in_y && (puck_x_i >= 12'(GOAL_R_X));
    in_l = in_y && (puck_x_i <= 12'(GOAL_L_X));
  end

  // Next-state, frame counter and score update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    case (state_q)
      StServe: begin
        if (frame_tick_i) begin
          // Counter saturates at the last serve frame until the puck is clear of both goals.
          if (cnt_q == ServeLast) begin
            if (!in_l && !in_r) state_d = StPlay;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPlay: begin
        cnt_d = '0;
        if (frame_tick_i && (in_r || in_l)) begin
          state_d = StGoal;
          // Right goal takes priority if both are flagged.
          if (in_r) begin
            if (p1_q != WinPts) p1_d = p1_q + 1'b1;
          end else begin
            if (p2_q != WinPts) p2_d = p2_q + 1'b1;
          end
        end
      end
      StGoal: begin
        cnt_d   = '0;
        state_d = ((p1_q == WinPts) || (p2_q == WinPts)) ? StOver : StServe;
      end
      StOver: begin
`ifdef SCORE_AUTO_RESTART_EN
        if (frame_tick_i) begin
          if (cnt_q == CntW'(RESTART_FRAMES - 1)) begin
            state_d = StServe;
            cnt_d   = '0;
            p1_d    = '0;
            p2_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = StServe;
    endcase
    // A new game overrides everything, including a goal scored in the same cycle.
    if (new_game_i) begin
      state_d = StServe;
      cnt_d   = '0;
      p1_d    = '0;
      p2_d    = '0;
    end
  end

  // Winner is decoded from the scores that will be held in the game-over state.
  always_comb begin
    winner_d = 2'b00;
    if (state_d == StOver) begin
      if (p1_d == WinPts)      winner_d = 2'b01;
      else if (p2_d == WinPts) winner_d = 2'b10;
      else                     winner_d = 2'b00;
    end
  end

  // State, counter, scores and registered output decodes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StServe;
      cnt_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      pulse_q  <= 1'b0;
      serve_q  <= 1'b1;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      pulse_q  <= (state_d == StGoal);
      serve_q  <= (state_d == StServe);
      over_q   <= (state_d == StOver);
      winner_q <= winner_d;
    end
  end

  assign player_1_point_o = p1_q;
  assign player_2_point_o = p2_q;
  assign goal_pulse_o     = pulse_q;
  assign serve_o          = serve_q;
  assign game_over_o      = over_q;
  assign winner_o         = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table-driven goal-detection vectors, hand-written multi-frame sequences,
// and a randomized run compared every cycle against a behavioural reference model.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        ng = 1'b0;
  logic [11:0] px = 12'd512;
  logic [11:0] py = 12'd384;
  logic [1:0]  p1, p2, win;
  logic        pulse, serve, over;
  logic [8:0]  outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .frame_tick_i     (tick),
    .puck_x_i         (px),
    .puck_y_i         (py),
    .new_game_i       (ng),
    .player_1_point_o (p1),
    .player_2_point_o (p2),
    .goal_pulse_o     (pulse),
    .serve_o          (serve),
    .game_over_o      (over),
    .winner_o         (win)
  );

  // {serve, game_over, goal_pulse, p1, p2, winner}
  assign outs = {serve, over, pulse, p1, p2, win};

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {srv,ovr,pls,p1,p2,win}=%b expected %b", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {MServe, MPlay, MGoal, MOver} mph_t;
  mph_t m_ph;
  int   m_p1, m_p2, m_ticks;

  task automatic model_reset();
    m_ph = MServe; m_p1 = 0; m_p2 = 0; m_ticks = 0;
  endtask

  task automatic model_edge();
    bit r, l;
    if (!rst_n || ng) begin
      model_reset();
      return;
    end
    r = (px >= 1003) && (py >= 284) && (py <= 483);
    l = (px <= 20) && (py >= 284) && (py <= 483);
    case (m_ph)
      MServe: if (tick) begin
        m_ticks++;
        if (m_ticks >= 60 && !r && !l) m_ph = MPlay;
      end
      MPlay: if (tick && (r || l)) begin
        if (r) m_p1++; else m_p2++;
        m_ph = MGoal;
      end
      MGoal: begin
        m_ph = (m_p1 == 3 || m_p2 == 3) ? MOver : MServe;
        m_ticks = 0;
      end
      MOver: begin
`ifdef SCORE_AUTO_RESTART_EN
        if (tick) begin
          m_ticks++;
          if (m_ticks == 180) model_reset();
        end
`endif
      end
      default: model_reset();
    endcase
  endtask

  function automatic logic [8:0] model_outs();
    logic [1:0] w;
    w = (m_ph != MOver) ? 2'b00 : (m_p1 == 3) ? 2'b01 : 2'b10;
    return {m_ph == MServe, m_ph == MOver, m_ph == MGoal, 2'(m_p1), 2'(m_p2), w};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; ng = 1'b0;
    model_reset();
    cyc(); cyc();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic to_play();
    do_reset();
    px = 12'd512; py = 12'd384;
    frames(60);
  endtask

  task automatic score_right();
    px = 12'd1010; py = 12'd400; tick = 1'b1; cyc();
    tick = 1'b0; px = 12'd512; py = 12'd384; cyc();
  endtask

  typedef struct {
    string       name;
    logic        t;
    logic [11:0] x;
    logic [11:0] y;
    logic        n;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Single frame applied in PLAY; result one cycle later.
    vecs[0]  = '{"r_corner_top",  1'b1, 12'd1003, 12'd284, 1'b0, 9'b0_0_1_01_00_00};
    vecs[1]  = '{"r_x_short",     1'b1, 12'd1002, 12'd400, 1'b0, 9'b0_0_0_00_00_00};
    vecs[2]  = '{"r_y_above",     1'b1, 12'd1003, 12'd283, 1'b0, 9'b0_0_0_00_00_00};
    vecs[3]  = '{"r_corner_bot",  1'b1, 12'd1003, 12'd483, 1'b0, 9'b0_0_1_01_00_00};
    vecs[4]  = '{"r_y_below",     1'b1, 12'd1003, 12'd484, 1'b0, 9'b0_0_0_00_00_00};
    vecs[5]  = '{"l_edge",        1'b1, 12'd20,   12'd400, 1'b0, 9'b0_0_1_00_01_00};
    vecs[6]  = '{"l_x_short",     1'b1, 12'd21,   12'd400, 1'b0, 9'b0_0_0_00_00_00};
    vecs[7]  = '{"l_y_above",     1'b1, 12'd20,   12'd283, 1'b0, 9'b0_0_0_00_00_00};
    vecs[8]  = '{"l_corner_bot",  1'b1, 12'd0,    12'd483, 1'b0, 9'b0_0_1_00_01_00};
    vecs[9]  = '{"centre",        1'b1, 12'd512,  12'd384, 1'b0, 9'b0_0_0_00_00_00};
    vecs[10] = '{"no_tick_goal",  1'b0, 12'd1010, 12'd400, 1'b0, 9'b0_0_0_00_00_00};
    vecs[11] = '{"ng_with_goal",  1'b1, 12'd1010, 12'd400, 1'b1, 9'b1_0_0_00_00_00};

    // Reset values, sampled while reset is held.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check("reset_values", outs, 9'b1_0_0_00_00_00);

    // Serve drops exactly one cycle after the 60th tick.
    do_reset();
    px = 12'd512; py = 12'd384;
    frames(59);
    check("serve_after_59", outs, 9'b1_0_0_00_00_00);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("play_after_60", outs, 9'b0_0_0_00_00_00);

    // Goal-detection table.
    foreach (vecs[i]) begin
      to_play();
      tick = vecs[i].t; px = vecs[i].x; py = vecs[i].y; ng = vecs[i].n;
      cyc();
      tick = 1'b0; ng = 1'b0; px = 12'd512; py = 12'd384;
      check(vecs[i].name, outs, vecs[i].exp);
    end

    // Goal pulse lasts one cycle, then back to serve.
    to_play();
    px = 12'd1010; py = 12'd400; tick = 1'b1; cyc(); tick = 1'b0; px = 12'd512;
    check("goal_cycle", outs, 9'b0_0_1_01_00_00);
    cyc();
    check("serve_after_goal", outs, 9'b1_0_0_01_00_00);

    // Puck parked in a goal mouth holds the serve past 60 ticks.
    do_reset();
    px = 12'd10; py = 12'd400;
    frames(70);
    check("serve_held", outs, 9'b1_0_0_00_00_00);
    px = 12'd512; py = 12'd384; tick = 1'b1; cyc(); tick = 1'b0;
    check("serve_released", outs, 9'b0_0_0_00_00_00);

    // new_game during the goal cycle.
    to_play();
    px = 12'd1010; py = 12'd400; tick = 1'b1; cyc(); tick = 1'b0; px = 12'd512;
    ng = 1'b1; cyc(); ng = 1'b0;
    check("ng_in_goal", outs, 9'b1_0_0_00_00_00);

    // Asynchronous reset mid-game, checked before the next clock edge.
    to_play();
    score_right();
    frames(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("async_reset", outs, 9'b1_0_0_00_00_00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Three right goals end the game; later goals do not change the score.
    to_play();
    score_right(); frames(60);
    score_right(); frames(60);
    px = 12'd1010; py = 12'd400; tick = 1'b1; cyc(); tick = 1'b0;
    check("third_goal", outs, 9'b0_0_1_11_00_00);
    cyc();
    check("game_over", outs, 9'b0_1_0_11_00_01);
    frames(10);
    check("over_frozen", outs, 9'b0_1_0_11_00_01);
`ifdef SCORE_AUTO_RESTART_EN
    frames(169);
    check("over_before_restart", outs, 9'b0_1_0_11_00_01);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("auto_restart", outs, 9'b1_0_0_00_00_00);
`else
    frames(190);
    check("over_held", outs, 9'b0_1_0_11_00_01);
`endif
    ng = 1'b1; cyc(); ng = 1'b0;
    check("ng_from_over", outs, 9'b1_0_0_00_00_00);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      tick = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 7))
        0:       px = 12'($urandom_range(0, 25));
        1:       px = 12'($urandom_range(998, 1023));
        default: px = 12'($urandom_range(30, 990));
      endcase
      py = 12'($urandom_range(270, 500));
      ng = (m_ph == MOver) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 999) == 0);
      cyc();
      check("random", outs, model_outs());
    end
    tick = 1'b0; ng = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
